// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook timer: digit-triple type,
// cook-time presets, beep duration and BCD helper functions.
// Optional feature macro used by the timer: COOK_TIMER_BEEP_EN.
package microwave_pkg;

    // Remaining time as minutes / seconds-tens / seconds-ones BCD digits.
    typedef struct packed {
        logic [3:0] min;
        logic [2:0] tens;
        logic [3:0] ones;
    } digits_t;

    // Cook-time preset selected by the mode input.
    typedef enum logic [1:0] {
        MODE_30S  = 2'd0,
        MODE_1M   = 2'd1,
        MODE_2M30 = 2'd2,
        MODE_5M   = 2'd3
    } mode_t;

    // Countdown bookkeeping: armed until the end pulse has been issued.
    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_DONE  = 1'b1
    } timer_state_t;

    localparam digits_t PRESET_30S  = '{min: 4'd0, tens: 3'd3, ones: 4'd0};
    localparam digits_t PRESET_1M   = '{min: 4'd1, tens: 3'd0, ones: 4'd0};
    localparam digits_t PRESET_2M30 = '{min: 4'd2, tens: 3'd3, ones: 4'd0};
    localparam digits_t PRESET_5M   = '{min: 4'd5, tens: 3'd0, ones: 4'd0};

    // Length of the end-of-cook beep, in countdown seconds.
    localparam int BEEP_SECONDS = 3;

    function automatic digits_t preset(input logic [1:0] mode);
        digits_t result;
        case (mode_t'(mode))
            MODE_30S:  result = PRESET_30S;
            MODE_1M:   result = PRESET_1M;
            MODE_2M30: result = PRESET_2M30;
            default:   result = PRESET_5M;
        endcase
        return result;
    endfunction

    function automatic logic is_zero(input digits_t d);
        return (d == '0);
    endfunction

    // One-second BCD decrement with borrow; saturates at 0:00.
    function automatic digits_t bcd_dec(input digits_t d);
        digits_t result;
        result = d;
        if (d != '0) begin
            if (d.ones != 4'd0) begin
                result.ones = d.ones - 4'd1;
            end else begin
                result.ones = 4'd9;
                if (d.tens != 3'd0) begin
                    result.tens = d.tens - 3'd1;
                end else begin
                    result.tens = 3'd5;
                    result.min  = d.min - 4'd1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cook_timer_if.sv
// Bundle between the microwave controller (master) and the cook timer
// (slave). The beep line exists only when COOK_TIMER_BEEP_EN is defined.
interface cook_timer_if;
    logic [1:0] mode;
    logic       start;
    logic       idle;
    logic [3:0] min;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timerEnd;
`ifdef COOK_TIMER_BEEP_EN
    logic       beep;

    modport master (output mode, start, idle,
                    input  min, sec_tens, sec_ones, timerEnd, beep);
    modport slave  (input  mode, start, idle,
                    output min, sec_tens, sec_ones, timerEnd, beep);
`else
    modport master (output mode, start, idle,
                    input  min, sec_tens, sec_ones, timerEnd);
    modport slave  (input  mode, start, idle,
                    output min, sec_tens, sec_ones, timerEnd);
`endif
endinterface

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, holds while
// disabled, and emits a single-cycle tick on the cycle it wraps to 0.
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count_reg;

    // Tick is combinational so the digits step on the same edge as the wrap.
    assign tick = enable && !clear && (count_reg == LAST);

    // Prescaler count: clear wins, otherwise advance only while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: loads a BCD preset while idle, counts down once
// per second while cooking, pauses otherwise, and pulses timerEnd once
// when 0:00 is reached. Define COOK_TIMER_BEEP_EN to add the beep output.
module cook_timer
    import microwave_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input logic         clk,
    input logic         rst,
    cook_timer_if.slave bus
);
    digits_t      digits_reg;
    timer_state_t state_reg;
    logic         timer_end_reg;
    logic         tick;
    logic         fire;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.start & ~bus.idle),
        .clear  (bus.idle),
        .tick   (tick)
    );

    // End condition: reached 0:00 and no pulse issued since the last re-arm.
    assign fire = !bus.idle && (state_reg == ST_ARMED) && is_zero(digits_reg);

    // Digit countdown and the armed/done state with its end pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_reg    <= PRESET_30S;
            state_reg     <= ST_ARMED;
            timer_end_reg <= 1'b0;
        end else begin
            timer_end_reg <= 1'b0;
            if (bus.idle) begin
                digits_reg <= preset(bus.mode);
                state_reg  <= ST_ARMED;
            end else begin
                if (tick) begin
                    digits_reg <= bcd_dec(digits_reg);
                end
                if (fire) begin
                    timer_end_reg <= 1'b1;
                    state_reg     <= ST_DONE;
                end
            end
        end
    end

    assign bus.min      = digits_reg.min;
    assign bus.sec_tens = digits_reg.tens;
    assign bus.sec_ones = digits_reg.ones;
    assign bus.timerEnd = timer_end_reg;

`ifdef COOK_TIMER_BEEP_EN
    localparam int BEEP_CYCLES = BEEP_SECONDS * CLK_HZ;
    localparam int BW = $clog2(BEEP_CYCLES);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

    logic          beep_reg;
    logic [BW-1:0] beep_count_reg;

    // Beep starts with the end pulse and runs a fixed number of cycles;
    // returning to idle silences it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_reg       <= 1'b0;
            beep_count_reg <= '0;
        end else if (bus.idle) begin
            beep_reg       <= 1'b0;
            beep_count_reg <= '0;
        end else if (fire) begin
            beep_reg       <= 1'b1;
            beep_count_reg <= '0;
        end else if (beep_reg) begin
            if (beep_count_reg == BEEP_LAST) begin
                beep_reg       <= 1'b0;
                beep_count_reg <= '0;
            end else begin
                beep_count_reg <= beep_count_reg + 1'b1;
            end
        end
    end

    assign bus.beep = beep_reg;
`endif
endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer at CLK_HZ=4: a table of input rows, each
// held for a number of cycles and then checked, plus beep sequences when
// COOK_TIMER_BEEP_EN is defined.
module tb_cook_timer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   pulse_cnt;

    cook_timer_if bus ();

    cook_timer #(.CLK_HZ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count end pulses as seen on the sampling edge.
    always @(negedge clk) begin
        if (bus.timerEnd === 1'b1) pulse_cnt++;
    end

    typedef struct {
        string      name;
        logic       r;
        logic       i;
        logic       s;
        logic [1:0] m;
        int         n;
        logic [3:0] emin;
        logic [2:0] etens;
        logic [3:0] eones;
        logic       eend;
        int         epulse;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input bit r, input bit i, input bit s,
                       input int m, input int n, input int mi, input int te,
                       input int on, input bit e, input int p);
        vec_t v;
        v.name   = nm;
        v.r      = r;
        v.i      = i;
        v.s      = s;
        v.m      = m[1:0];
        v.n      = n;
        v.emin   = mi[3:0];
        v.etens  = te[2:0];
        v.eones  = on[3:0];
        v.eend   = e;
        v.epulse = p;
        vecs.push_back(v);
    endtask

    task automatic check_row(input int idx, input vec_t v);
        checks++;
        if (bus.min !== v.emin || bus.sec_tens !== v.etens || bus.sec_ones !== v.eones ||
            bus.timerEnd !== v.eend || pulse_cnt != v.epulse) begin
            errors++;
            $display("FAIL %s: got %0d:%0d%0d end=%0b pulses=%0d, expected %0d:%0d%0d end=%0b pulses=%0d",
                     v.name, bus.min, bus.sec_tens, bus.sec_ones, bus.timerEnd, pulse_cnt,
                     v.emin, v.etens, v.eones, v.eend, v.epulse);
        end else begin
            $display("vec %0d %s: %0d:%0d%0d end=%0b pulses=%0d", idx, v.name,
                     bus.min, bus.sec_tens, bus.sec_ones, bus.timerEnd, pulse_cnt);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", nm, got, want);
        end else begin
            $display("chk %s: %0b", nm, got);
        end
    endtask

`ifdef COOK_TIMER_BEEP_EN
    // Re-arm with mode 0 and run until the end pulse is on the outputs.
    task automatic run_to_end();
        bus.idle  = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        @(negedge clk);
        bus.idle  = 1'b0;
        bus.start = 1'b1;
        repeat (121) @(negedge clk);
        #1;
    endtask
`endif

    initial begin
        errors    = 0;
        checks    = 0;
        pulse_cnt = 0;
        rst       = 1'b1;
        bus.idle  = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 2'd0;

        //   name          rst idle start mode cycles  m  t  o  end pulses
        add("rst_state",    1, 0, 0, 0,   1,  0, 3, 0, 0, 0);
        add("idle_m2",      0, 1, 0, 2,   2,  2, 3, 0, 0, 0);
        add("idle_m1",      0, 1, 0, 1,   1,  1, 0, 0, 0, 0);
        add("pre_tick",     0, 0, 1, 1,   3,  1, 0, 0, 0, 0);
        add("tick_100_059", 0, 0, 1, 1,   1,  0, 5, 9, 0, 0);
        add("run_to_050",   0, 0, 1, 1,  36,  0, 5, 0, 0, 0);
        add("b_050_049",    0, 0, 1, 1,   4,  0, 4, 9, 0, 0);
        add("mode_ignored", 0, 0, 1, 3,   4,  0, 4, 8, 0, 0);
        add("partial_pre",  0, 0, 1, 3,   2,  0, 4, 8, 0, 0);
        add("pause_10",     0, 0, 0, 3,  10,  0, 4, 8, 0, 0);
        add("resume_1",     0, 0, 1, 3,   1,  0, 4, 8, 0, 0);
        add("resume_tick",  0, 0, 1, 3,   1,  0, 4, 7, 0, 0);
        add("idle_start",   0, 1, 1, 0,   1,  0, 3, 0, 0, 0);
        add("idle_st_hold", 0, 1, 1, 0,   4,  0, 3, 0, 0, 0);
        add("count_029",    0, 0, 1, 0,   4,  0, 2, 9, 0, 0);
        add("run_to_012",   0, 0, 1, 0,  68,  0, 1, 2, 0, 0);
        add("rst_async",    1, 0, 1, 0,   0,  0, 3, 0, 0, 0);
        add("rst_held",     1, 0, 1, 0,   2,  0, 3, 0, 0, 0);
        add("rst_release",  0, 0, 1, 0,   4,  0, 2, 9, 0, 0);
        add("rearm_m0",     0, 1, 0, 0,   1,  0, 3, 0, 0, 0);
        add("run_to_001",   0, 0, 1, 0, 119,  0, 0, 1, 0, 0);
        add("reach_000",    0, 0, 1, 0,   1,  0, 0, 0, 0, 0);
        add("end_pulse",    0, 0, 1, 0,   1,  0, 0, 0, 1, 1);
        add("end_single",   0, 0, 1, 0,   1,  0, 0, 0, 0, 1);
        add("hold_000",     0, 0, 1, 0,  40,  0, 0, 0, 0, 1);
        add("rearm_m3",     0, 1, 0, 3,   1,  5, 0, 0, 0, 1);
        add("b_500_459",    0, 0, 1, 3,   4,  4, 5, 9, 0, 1);
        add("rearm_m0_b",   0, 1, 0, 0,   1,  0, 3, 0, 0, 1);
        add("run_to_000b",  0, 0, 1, 0, 120,  0, 0, 0, 0, 1);
        add("end_pulse2",   0, 0, 1, 0,   1,  0, 0, 0, 1, 2);

        @(negedge clk);
        foreach (vecs[k]) begin
            rst       = vecs[k].r;
            bus.idle  = vecs[k].i;
            bus.start = vecs[k].s;
            bus.mode  = vecs[k].m;
            repeat (vecs[k].n) @(negedge clk);
            #1;
            check_row(k, vecs[k]);
        end

`ifdef COOK_TIMER_BEEP_EN
        begin
            int high;
            run_to_end();
            check_bit("beep_end_pulse", bus.timerEnd, 1'b1);
            check_bit("beep_starts", bus.beep, 1'b1);
            high = 1;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                #1;
                if (bus.beep === 1'b1) high++;
            end
            checks++;
            if (high != 12) begin
                errors++;
                $display("FAIL beep_len: got %0d cycles, expected 12", high);
            end else begin
                $display("chk beep_len: %0d cycles", high);
            end

            run_to_end();
            check_bit("beep2_starts", bus.beep, 1'b1);
            repeat (4) @(negedge clk);
            #1;
            check_bit("beep2_cycle5", bus.beep, 1'b1);
            bus.idle  = 1'b1;
            bus.start = 1'b0;
            @(negedge clk);
            #1;
            check_bit("beep2_idle_clear", bus.beep, 1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001: Parameter CLK_HZ, default 100_000_000; clock cycles per one-second countdown tick (minimum 2).
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: mode  input  2  cook-time preset select from the mode-select stage.
REQ-005: start  input  1  level; high while the cooking state is active.
REQ-006: idle  input  1  level; high while the controller is idle.
REQ-007: min  output  4  remaining minutes, BCD 0-9.
REQ-008: sec_tens  output  3  remaining seconds tens digit, 0-5.
REQ-009: sec_ones  output  4  remaining seconds ones digit, BCD 0-9.
REQ-010: timerEnd  output  1  single-cycle pulse when the countdown reaches 0:00.

Function
REQ-011: Presets SHALL be: mode 0 = 0:30, mode 1 = 1:00, mode 2 = 2:30, mode 3 = 5:00.
REQ-012: While idle=1, the digit registers SHALL load the preset for the current mode every cycle, with 1-cycle latency, the prescaler SHALL clear, and the armed flag SHALL set.
REQ-013: When idle=1 and start=1 in the same cycle, idle SHALL take priority.
REQ-014: While start=1 and idle=0, the prescaler SHALL count 0..CLK_HZ-1; the digits decrement by one second in the cycle the prescaler wraps to 0.
REQ-015: While start=0 and idle=0 (pause), the digits SHALL hold and the prescaler SHALL hold its value.
REQ-016: Decrement SHALL borrow in BCD: sec_ones 0->9 borrowing from sec_tens; sec_tens 0->5 borrowing from min.
REQ-017: The digits SHALL never wrap below 0:00; at 0:00 further ticks leave them unchanged.
REQ-018: timerEnd SHALL pulse high for exactly one cycle, in the cycle after the digits become 0:00 while armed; the armed flag clears in the same cycle.
REQ-019: If start=1, idle=0 and the digits are already 0:00 while armed, timerEnd SHALL pulse on the next cycle without waiting for a tick.
REQ-020: After timerEnd, no further pulse SHALL occur until idle=1 re-arms the block.
REQ-021: A mode change while idle=0 SHALL have no effect on the countdown.

Reset
REQ-022: On rst=1, min/sec_tens/sec_ones SHALL be the mode-0 preset (0:30), timerEnd=0, prescaler=0, armed=1, beep=0, beep counter=0.
REQ-023: Reset mid-countdown SHALL abort immediately (asynchronously); counting resumes only after rst deasserts and start=1.

Configuration
REQ-024: Macro COOK_TIMER_BEEP_EN SHALL add output beep (1 bit), asserted from the cycle timerEnd pulses for exactly 3*CLK_HZ cycles, cleared early by idle=1 or rst.
REQ-025: Without COOK_TIMER_BEEP_EN, the beep port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026: Preset BCD constants, the digit-triple typedef and the beep duration constant SHALL live in shared package microwave_pkg.
REQ-027: The prescaler SHALL be a sub-module, tick_gen (inputs: clk, rst, enable, clear; output: single-cycle tick).

Verification (CLK_HZ=4)
REQ-028: rst, idle=1, mode=2 for 2 cycles -> display 2:30, timerEnd=0.
REQ-029: From 1:00, start=1 -> 0:59 after 4 cycles; 0:50->0:49 and 1:00->0:59 borrows are correct.
REQ-030: mode 0, start held -> 0:00 after 120 cycles; timerEnd pulses one cycle; digits stay 0:00 and no second pulse over 40 more cycles.
REQ-031: Pause (start=0, idle=0) for 10 cycles mid-count -> digits and prescaler frozen; the resume tick lands after the remaining prescaler count.
REQ-032: rst pulsed at 0:12 during countdown -> 0:30, timerEnd never pulses; idle=1 together with start=1 -> preset reloaded, no decrement.
REQ-033: With COOK_TIMER_BEEP_EN -> beep high for exactly 12 cycles after timerEnd; idle=1 at cycle 5 clears it at once.
